rob_flush: RTL and testbench

ROB_FLUSH -- requirements
Module: rob_flush

---
 rtl/rob_flush_pkg.sv | 15 +
 rtl/rob_flush_if.sv | 52 +++++
 rtl/rob_flush_retire_sel.sv | 22 ++
 rtl/rob_flush.sv | 131 +++++++++++++
 tb/tb_rob_flush.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rob_flush_pkg.sv
// Shared types and defaults for the reorder buffer.
// pipTypes holds the pipeline-wide entry payload.
package pipTypes;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        exc;
  } rob_entry_t;
endpackage

package rob_flush_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_INS   = 2;
  localparam int ROB_EXT   = 2;
endpackage

// File: rtl/rob_flush_if.sv
// Reorder buffer request/response bundle.
// master drives requests, slave is the buffer.
interface rob_flush_if
  import pipTypes::*;
  import rob_flush_pkg::*;
#(
  parameter type T         = rob_entry_t,
  parameter int  DEPTH     = ROB_DEPTH,
  parameter int  INS_COUNT = ROB_INS,
  parameter int  EXT_COUNT = ROB_EXT
);
  localparam int IW  = $clog2(DEPTH);
  localparam int RCW = $clog2(INS_COUNT + 1);
  localparam int ECW = $clog2(EXT_COUNT + 1);

  logic                         reserve;
  logic [RCW-1:0]               reserve_count;
  logic [INS_COUNT-1:0][IW-1:0] reserved_slots;
  logic                         reserve_ok;
  logic [INS_COUNT-1:0]         write_valid;
  logic [INS_COUNT-1:0][IW-1:0] write_slot;
  T                             write_data [INS_COUNT];
  logic [EXT_COUNT-1:0]         retire_valid;
  T                             retire_data [EXT_COUNT];
  logic [ECW-1:0]               retire_count;
  logic                         flush;
  logic [IW-1:0]                flush_slot;
  logic                         flush_all;
  logic [IW:0]                  used_count;
  logic                         empty;
  logic                         full;

  modport master (
    output reserve, reserve_count,
    output write_valid, write_slot, write_data,
    output retire_count,
    output flush, flush_slot, flush_all,
    input  reserved_slots, reserve_ok,
    input  retire_valid, retire_data,
    input  used_count, empty, full
  );

  modport slave (
    input  reserve, reserve_count,
    input  write_valid, write_slot, write_data,
    input  retire_count,
    input  flush, flush_slot, flush_all,
    output reserved_slots, reserve_ok,
    output retire_valid, retire_data,
    output used_count, empty, full
  );
endinterface

// File: rtl/rob_flush_retire_sel.sv
// Retire window selector: keeps the contiguous
// ready prefix of the head lanes and counts it.
module rob_retire_sel #(
  parameter int N = 2
) (
  input  logic [N-1:0]             ok_i,
  output logic [N-1:0]             mask_o,
  output logic [$clog2(N+1)-1:0]   cnt_o
);
  logic run;

  always_comb begin
    mask_o = '0;
    cnt_o  = '0;
    run    = 1'b1;
    for (int i = 0; i < N; i++) begin
      run       = run & ok_i[i];
      mask_o[i] = run;
      if (run) cnt_o = cnt_o + 1'b1;
    end
  end
endmodule

// File: rtl/rob_flush.sv
// Circular reorder buffer with multi-slot reserve,
// out-of-order completion, in-order retire and flush.
module rob_flush
  import pipTypes::*;
  import rob_flush_pkg::*;
#(
  parameter type T         = rob_entry_t,
  parameter int  DEPTH     = ROB_DEPTH,
  parameter int  INS_COUNT = ROB_INS,
  parameter int  EXT_COUNT = ROB_EXT
) (
  input  logic      clock,
  input  logic      reset,
  rob_flush_if.slave rob
);
  localparam int IW  = $clog2(DEPTH);
  localparam int RCW = $clog2(INS_COUNT + 1);
  localparam int ECW = $clog2(EXT_COUNT + 1);

  logic [IW-1:0]        head_q, head_d;
  logic [IW-1:0]        tail_q, tail_d;
  logic [IW:0]          used_q, used_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  T                     buf_q [DEPTH];

  logic [EXT_COUNT-1:0] lane_ok, ret_mask;
  logic [ECW-1:0]       ret_avail, ret_n;
  logic [INS_COUNT-1:0] wr_en;
  logic [IW-1:0]        flush_off;
  logic                 flush_ok, res_ok, acc;

  always_comb begin
    lane_ok = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      lane_ok[i] = ((IW+1)'(i) < used_q)
                && valid_q[head_q + IW'(i)];
    end
  end

  rob_retire_sel #(.N(EXT_COUNT)) u_sel (
    .ok_i   (lane_ok),
    .mask_o (ret_mask),
    .cnt_o  (ret_avail)
  );

  assign ret_n = (rob.retire_count > ret_avail)
               ? ret_avail : rob.retire_count;

  assign res_ok = ((IW+1)'(DEPTH) - used_q)
               >= (IW+1)'(INS_COUNT);
  assign acc = rob.reserve && res_ok
            && !rob.flush && !rob.flush_all;

  assign flush_off = rob.flush_slot - head_q;
  assign flush_ok  = rob.flush
                  && ({1'b0, flush_off} < used_q);

  always_comb begin
    head_d  = head_q + IW'(ret_n);
    tail_d  = tail_q;
    used_d  = used_q - (IW+1)'(ret_n);
    valid_d = valid_q;
    wr_en   = '0;
    for (int i = 0; i < INS_COUNT; i++) begin
      if (rob.write_valid[i]
          && ({1'b0, rob.write_slot[i] - head_q} < used_q))
        wr_en[i] = 1'b1;
    end
    if (rob.flush_all) begin
      tail_d  = head_d;
      used_d  = '0;
      valid_d = '0;
      wr_en   = '0;
    end else if (flush_ok) begin
      tail_d = rob.flush_slot + 1'b1;
      used_d = {1'b0, flush_off} + (IW+1)'(1)
             - (IW+1)'(ret_n);
      // completions landing on discarded slots vanish
      for (int i = 0; i < INS_COUNT; i++) begin
        if ((rob.write_slot[i] - head_q) > flush_off)
          wr_en[i] = 1'b0;
      end
    end else if (acc) begin
      tail_d = tail_q + IW'(rob.reserve_count);
      used_d = used_q - (IW+1)'(ret_n)
             + (IW+1)'(rob.reserve_count);
      for (int i = 0; i < INS_COUNT; i++) begin
        if (RCW'(i) < rob.reserve_count)
          valid_d[tail_q + IW'(i)] = 1'b0;
      end
    end
    for (int i = 0; i < INS_COUNT; i++) begin
      if (wr_en[i]) valid_d[rob.write_slot[i]] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      used_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      used_q  <= used_d;
      valid_q <= valid_d;
    end
  end

  // later lanes win on equal slots via NBA ordering
  always_ff @(posedge clock) begin
    for (int i = 0; i < INS_COUNT; i++) begin
      if (wr_en[i])
        buf_q[rob.write_slot[i]] <= rob.write_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < INS_COUNT; i++)
      rob.reserved_slots[i] = tail_q + IW'(i);
    for (int i = 0; i < EXT_COUNT; i++)
      rob.retire_data[i] = buf_q[head_q + IW'(i)];
  end

  assign rob.reserve_ok   = res_ok;
  assign rob.retire_valid = ret_mask;
  assign rob.used_count   = used_q;
  assign rob.empty        = (used_q == '0);
  assign rob.full         = (used_q == (IW+1)'(DEPTH));
endmodule

// File: tb/tb_rob_flush.sv
// Directed bench for rob_flush at DEPTH=8,
// two insert and two retire lanes.
module tb_rob_flush;
  import pipTypes::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rob_flush_if #(
    .T(rob_entry_t), .DEPTH(8),
    .INS_COUNT(2), .EXT_COUNT(2)
  ) rif ();

  rob_flush #(
    .T(rob_entry_t), .DEPTH(8),
    .INS_COUNT(2), .EXT_COUNT(2)
  ) dut (
    .clock (clk),
    .reset (rst),
    .rob   (rif.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rob_entry_t mk(input int n);
    rob_entry_t e;
    e.pc  = 32'h1000 + 32'(n * 4);
    e.rd  = 5'(n);
    e.exc = 1'b0;
    return e;
  endfunction

  task automatic idle();
    rif.reserve       = 1'b0;
    rif.reserve_count = '0;
    rif.write_valid   = '0;
    rif.retire_count  = '0;
    rif.flush         = 1'b0;
    rif.flush_slot    = '0;
    rif.flush_all     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rif.write_slot[i] = '0;
      rif.write_data[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsv2();
    rif.reserve = 1'b1;
    rif.reserve_count = 2'd2;
    tick();
    idle();
  endtask

  task automatic wr(input int l, input int s,
                    input rob_entry_t d);
    rif.write_valid[l] = 1'b1;
    rif.write_slot[l]  = 3'(s);
    rif.write_data[l]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string p);
    chk({p, "_used"},  64'(rif.used_count), 64'd0);
    chk({p, "_empty"}, 64'(rif.empty), 64'd1);
    chk({p, "_full"},  64'(rif.full), 64'd0);
    chk({p, "_rok"},   64'(rif.reserve_ok), 64'd1);
    chk({p, "_rv"},    64'(rif.retire_valid), 64'd0);
    chk({p, "_rs0"},   64'(rif.reserved_slots[0]), 64'd0);
    chk({p, "_rs1"},   64'(rif.reserved_slots[1]), 64'd1);
  endtask

  initial begin
    idle();
    do_reset();
    chk_reset_state("rst");

    // fill to full, then a rejected fifth reserve
    for (int k = 1; k <= 4; k++) begin
      rsv2();
      chk("fill_used", 64'(rif.used_count), 64'(2 * k));
    end
    chk("fill_full", 64'(rif.full), 64'd1);
    chk("fill_rok",  64'(rif.reserve_ok), 64'd0);
    rsv2();
    chk("over_used", 64'(rif.used_count), 64'd8);
    chk("over_tail", 64'(rif.reserved_slots[0]), 64'd0);

    // out-of-order completion and retire prefix
    do_reset();
    rsv2();
    wr(0, 1, mk(11));
    tick(); idle();
    chk("ooo_rv00", 64'(rif.retire_valid), 64'd0);
    rif.retire_count = 2'd2;
    tick(); idle();
    chk("clamp_used", 64'(rif.used_count), 64'd2);
    chk("clamp_head", 64'(dut.head_q), 64'd0);
    wr(0, 0, mk(7));
    wr(1, 0, mk(10));
    tick(); idle();
    chk("ooo_rv11", 64'(rif.retire_valid), 64'd3);
    chk("rdata0", 64'(rif.retire_data[0]), 64'(mk(10)));
    chk("rdata1", 64'(rif.retire_data[1]), 64'(mk(11)));
    rif.retire_count = 2'd2;
    tick(); idle();
    chk("ret_head", 64'(dut.head_q), 64'd2);
    chk("ret_used", 64'(rif.used_count), 64'd0);
    chk("ret_empty", 64'(rif.empty), 64'd1);

    // walk head to 6, then retire+reserve across wrap
    rsv2(); rsv2();
    wr(0, 2, mk(2)); wr(1, 3, mk(3));
    tick(); idle();
    wr(0, 4, mk(4)); wr(1, 5, mk(5));
    tick(); idle();
    for (int k = 0; k < 2; k++) begin
      rif.retire_count = 2'd2;
      tick(); idle();
    end
    chk("walk_head", 64'(dut.head_q), 64'd6);
    chk("walk_used", 64'(rif.used_count), 64'd0);
    rsv2(); rsv2();
    wr(0, 6, mk(6)); wr(1, 7, mk(8));
    tick(); idle();
    chk("wrap_rv", 64'(rif.retire_valid), 64'd3);
    rif.retire_count  = 2'd2;
    rif.reserve       = 1'b1;
    rif.reserve_count = 2'd2;
    tick(); idle();
    chk("wrap_head", 64'(dut.head_q), 64'd0);
    chk("wrap_tail", 64'(rif.reserved_slots[0]), 64'd4);
    chk("wrap_used", 64'(rif.used_count), 64'd4);

    // partial flush drops younger completions
    do_reset();
    rsv2(); rsv2(); rsv2();
    chk("pf_pre", 64'(rif.used_count), 64'd6);
    rif.flush      = 1'b1;
    rif.flush_slot = 3'd2;
    wr(0, 4, mk(4));
    tick(); idle();
    chk("pf_tail", 64'(rif.reserved_slots[0]), 64'd3);
    chk("pf_used", 64'(rif.used_count), 64'd3);
    chk("pf_v4",   64'(dut.valid_q[4]), 64'd0);
    rif.flush      = 1'b1;
    rif.flush_slot = 3'd6;
    tick(); idle();
    chk("badfl_used", 64'(rif.used_count), 64'd3);
    chk("badfl_tail", 64'(rif.reserved_slots[0]), 64'd3);
    wr(0, 5, mk(5));
    tick(); idle();
    chk("oor_v5", 64'(dut.valid_q[5]), 64'd0);

    // flush_all beats reserve; retire still counts
    wr(0, 0, mk(1));
    tick(); idle();
    chk("fa_rv", 64'(rif.retire_valid), 64'd1);
    rif.flush_all     = 1'b1;
    rif.reserve       = 1'b1;
    rif.reserve_count = 2'd2;
    rif.retire_count  = 2'd1;
    tick(); idle();
    chk("fa_used",  64'(rif.used_count), 64'd0);
    chk("fa_empty", 64'(rif.empty), 64'd1);
    chk("fa_head",  64'(dut.head_q), 64'd1);
    chk("fa_tail",  64'(rif.reserved_slots[0]), 64'd1);

    // reset overrides concurrent activity
    rsv2();
    chk("mid_used", 64'(rif.used_count), 64'd2);
    wr(0, 1, mk(3));
    wr(1, 2, mk(4));
    rif.reserve       = 1'b1;
    rif.reserve_count = 2'd2;
    rif.retire_count  = 2'd1;
    rst = 1'b1;
    tick();
    idle();
    chk_reset_state("mid");
    chk("mid_valid", 64'(dut.valid_q), 64'd0);
    rst = 1'b0;
    tick();
    chk_reset_state("post");

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
